// File: rtl/bank_scheduler.sv
// Write-port arbiter and bank-swap scheduler for the life board.
// Sequences init, preset load and evolution rounds, and commits swaps on vsync.
module bank_scheduler #(
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_done,
   input  logic             preset_req,
   input  logic             preset_done,
   input  logic             evo_tick,
   input  logic             round_done,
   input  logic             frame_end,
   input  logic             clear,
   output logic             init_start,
   output logic             round_start,
   output logic [1:0]       owner,
   output logic             active_bank,
   output logic             vga_blank,
   output logic [GEN_W-1:0] gen_count,
   output logic             tick_overrun
);

   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_PRESET = 3'd1;
   localparam logic [2:0] S_IDLE   = 3'd2;
   localparam logic [2:0] S_EVOLVE = 3'd3;
   localparam logic [2:0] S_SWAP   = 3'd4;

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       to_init;
   logic       commit;
   logic       arm;
   logic       pend;
   logic       clr_pend;

   // Next-state selection; to_init marks a wipe, commit marks a vsync swap.
   always_comb begin
      state_nx = state;
      to_init  = 1'b0;
      commit   = 1'b0;
      case (state)
         S_INIT: begin
            if (clear)
               to_init = 1'b1;
            else if (init_done && !arm)
               state_nx = S_IDLE;
         end
         S_PRESET: begin
            if (clear)
               to_init = 1'b1;
            else if (preset_done)
               state_nx = S_IDLE;
         end
         S_IDLE: begin
            if (clear)
               to_init = 1'b1;
            else if (preset_req)
               state_nx = S_PRESET;
            else if (evo_tick || pend)
               state_nx = S_EVOLVE;
         end
         S_EVOLVE: begin
            if (round_done) begin
               if (clear || clr_pend)
                  to_init = 1'b1;
               else
                  state_nx = S_SWAP;
            end
         end
         S_SWAP: begin
            if (clear)
               to_init = 1'b1;
            else if (frame_end) begin
               commit   = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_INIT;
      endcase
      if (to_init)
         state_nx = S_INIT;
   end

   // Decode the write-port owner and video blanking from the state.
   always_comb begin
      owner     = 2'd0;
      vga_blank = 1'b0;
      case (state)
         S_INIT: begin
            owner     = 2'd1;
            vga_blank = 1'b1;
         end
         S_PRESET: begin
            owner     = 2'd2;
            vga_blank = 1'b1;
         end
         S_EVOLVE: owner = 2'd3;
         default:  owner = 2'd0;
      endcase
   end

   // State, start pulses, tick bookkeeping and committed bank/generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_INIT;
         arm          <= 1'b1;
         init_start   <= 1'b0;
         round_start  <= 1'b0;
         active_bank  <= 1'b0;
         gen_count    <= '0;
         tick_overrun <= 1'b0;
         pend         <= 1'b0;
         clr_pend     <= 1'b0;
      end else begin
         state       <= state_nx;
         arm         <= 1'b0;
         init_start  <= to_init | arm;
         round_start <= (state == S_IDLE) && (state_nx == S_EVOLVE);

         if (state != S_IDLE && evo_tick && pend)
            tick_overrun <= 1'b1;

         if (to_init)
            pend <= 1'b0;
         else if (state == S_IDLE) begin
            if (state_nx == S_EVOLVE)
               pend <= 1'b0;
            else if (evo_tick)
               pend <= 1'b1;
         end else if (evo_tick)
            pend <= 1'b1;

         if (state != S_EVOLVE || round_done)
            clr_pend <= 1'b0;
         else if (clear)
            clr_pend <= 1'b1;

         if (to_init) begin
            active_bank <= 1'b0;
            gen_count   <= '0;
         end else if (commit) begin
            active_bank <= ~active_bank;
            gen_count   <= gen_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bank_scheduler.sv
// Self-checking bench for bank_scheduler: directed scenarios plus
// random pulses, compared every cycle against an event-level model.
module tb_bank_scheduler;

   localparam int GEN_W = 3;

   localparam logic [6:0] CLR = 7'h40;
   localparam logic [6:0] IND = 7'h20;
   localparam logic [6:0] PRQ = 7'h10;
   localparam logic [6:0] PDN = 7'h08;
   localparam logic [6:0] TCK = 7'h04;
   localparam logic [6:0] RDN = 7'h02;
   localparam logic [6:0] FEN = 7'h01;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             init_done = 1'b0;
   logic             preset_req = 1'b0;
   logic             preset_done = 1'b0;
   logic             evo_tick = 1'b0;
   logic             round_done = 1'b0;
   logic             frame_end = 1'b0;
   logic             clear = 1'b0;
   logic             init_start;
   logic             round_start;
   logic [1:0]       owner;
   logic             active_bank;
   logic             vga_blank;
   logic [GEN_W-1:0] gen_count;
   logic             tick_overrun;

   bank_scheduler #(.GEN_W(GEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .init_done    (init_done),
      .preset_req   (preset_req),
      .preset_done  (preset_done),
      .evo_tick     (evo_tick),
      .round_done   (round_done),
      .frame_end    (frame_end),
      .clear        (clear),
      .init_start   (init_start),
      .round_start  (round_start),
      .owner        (owner),
      .active_bank  (active_bank),
      .vga_blank    (vga_blank),
      .gen_count    (gen_count),
      .tick_overrun (tick_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef enum int {M_INIT, M_PRESET, M_IDLE, M_EVOLVE, M_SWAP} mode_t;

   mode_t       m_mode;
   bit          m_fresh;
   bit          m_init;
   bit          m_round;
   bit          m_bank;
   bit          m_over;
   bit          m_wait;
   bit          m_clr;
   int unsigned m_gen;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_INIT;
      m_fresh = 1'b1;
      m_init  = 1'b0;
      m_round = 1'b0;
      m_bank  = 1'b0;
      m_over  = 1'b0;
      m_wait  = 1'b0;
      m_clr   = 1'b0;
      m_gen   = 0;
   endtask

   task automatic wipe();
      m_mode = M_INIT;
      m_gen  = 0;
      m_bank = 1'b0;
      m_wait = 1'b0;
      m_clr  = 1'b0;
      m_init = 1'b1;
   endtask

   // One clock edge of the scheduler, written from the behavioural rules.
   task automatic model_step(input logic [6:0] v);
      bit c, ini, prq, pdn, tk, rd, fe, was_fresh;
      {c, ini, prq, pdn, tk, rd, fe} = v;
      m_init    = m_fresh;
      m_round   = 1'b0;
      was_fresh = m_fresh;
      m_fresh   = 1'b0;
      if (m_mode != M_IDLE && tk) begin
         if (m_wait) m_over = 1'b1;
         m_wait = 1'b1;
      end
      case (m_mode)
         M_INIT: begin
            if (c) wipe();
            else if (ini && !was_fresh) m_mode = M_IDLE;
         end
         M_PRESET: begin
            if (c) wipe();
            else if (pdn) m_mode = M_IDLE;
         end
         M_IDLE: begin
            if (c) wipe();
            else if (prq) begin
               m_mode = M_PRESET;
               if (tk) m_wait = 1'b1;
            end else if (tk || m_wait) begin
               m_mode  = M_EVOLVE;
               m_wait  = 1'b0;
               m_round = 1'b1;
            end
         end
         M_EVOLVE: begin
            if (c) m_clr = 1'b1;
            if (rd) begin
               if (m_clr) wipe();
               else m_mode = M_SWAP;
            end
         end
         default: begin
            if (c) wipe();
            else if (fe) begin
               m_bank = !m_bank;
               m_gen  = (m_gen + 1) % (1 << GEN_W);
               m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   function automatic logic [1:0] exp_owner();
      case (m_mode)
         M_INIT:   return 2'd1;
         M_PRESET: return 2'd2;
         M_EVOLVE: return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

   task automatic compare_all();
      check("init_start", init_start, m_init);
      check("round_start", round_start, m_round);
      check("owner", owner, exp_owner());
      check("vga_blank", vga_blank,
            (m_mode == M_INIT || m_mode == M_PRESET));
      check("active_bank", active_bank, m_bank);
      check("gen_count", gen_count, m_gen);
      check("tick_overrun", tick_overrun, m_over);
      check("start_excl", init_start & round_start, 0);
   endtask

   task automatic step(input logic [6:0] v);
      compare_all();
      {clear, init_done, preset_req, preset_done,
       evo_tick, round_done, frame_end} = v;
      @(posedge clk);
      model_step(v);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(7'h00);
   endtask

   task automatic do_reset();
      {clear, init_done, preset_req, preset_done,
       evo_tick, round_done, frame_end} = 7'h00;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      rst = 1'b0;
   endtask

   task automatic boot();
      do_reset();
      step(7'h00);
      check("r38_init_pulse", init_start, 1);
      check("r38_owner_init", owner, 1);
      idle(18);
      check("r38_blank_init", vga_blank, 1);
      step(IND);
      check("r38_owner_idle", owner, 0);
      check("r38_blank_idle", vga_blank, 0);
   endtask

   logic [6:0] v;
   bit         prq_lvl;

   initial begin
      @(negedge clk);
      // Release from reset, init completes 20 cycles later
      boot();

      // Full round, swap only on the following frame_end
      step(TCK);
      check("r39_round_start", round_start, 1);
      check("r39_owner_evo", owner, 3);
      idle(99);
      step(RDN);
      idle(49);
      check("r39_bank_hold", active_bank, 0);
      check("r39_gen_hold", gen_count, 0);
      step(FEN);
      check("r39_bank", active_bank, 1);
      check("r39_gen", gen_count, 1);

      // round_done coinciding with frame_end does not commit
      boot();
      step(TCK);
      idle(99);
      step(RDN | FEN);
      check("r40_no_swap", gen_count, 0);
      check("r40_owner_wait", owner, 0);
      idle(199);
      step(FEN);
      check("r40_gen", gen_count, 1);
      check("r40_bank", active_bank, 1);

      // Three ticks during one round: overrun, one queued rerun
      boot();
      step(TCK);
      idle(5);
      step(TCK);
      idle(3);
      step(TCK);
      step(TCK);
      check("r41_overrun", tick_overrun, 1);
      idle(2);
      step(RDN);
      idle(3);
      step(FEN);
      check("r41_gen1", gen_count, 1);
      step(7'h00);
      check("r41_rerun", round_start, 1);
      idle(10);
      step(RDN);
      step(FEN);
      check("r41_gen2", gen_count, 2);
      check("r41_sticky", tick_overrun, 1);

      // clear during a round wipes instead of swapping
      boot();
      step(TCK);
      step(RDN);
      step(FEN);
      check("r42_pre_gen", gen_count, 1);
      idle(2);
      step(TCK);
      idle(4);
      step(CLR);
      idle(3);
      check("r42_still_evo", owner, 3);
      step(RDN);
      check("r42_owner", owner, 1);
      check("r42_init_pulse", init_start, 1);
      check("r42_gen", gen_count, 0);
      check("r42_bank", active_bank, 0);

      // preset wins over a simultaneous tick, which then runs
      boot();
      step(PRQ | TCK);
      check("r43_owner_preset", owner, 2);
      repeat (5) step(PRQ);
      step(PDN);
      check("r43_owner_idle", owner, 0);
      step(7'h00);
      check("r43_owner_evo", owner, 3);
      check("r43_round_start", round_start, 1);

      // Random traffic with occasional mid-run resets
      boot();
      prq_lvl = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 699) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 39) == 0) prq_lvl = !prq_lvl;
            v = 7'h00;
            v[6] = ($urandom_range(0, 79) == 0);
            v[5] = ($urandom_range(0, 11) == 0);
            v[4] = prq_lvl;
            v[3] = ($urandom_range(0, 11) == 0);
            v[2] = ($urandom_range(0, 14) == 0);
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 7) == 0);
            step(v);
         end
      end
      compare_all();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bank_scheduler.md
BANK_SCHEDULER -- requirements
Module: bank_scheduler

Interface
REQ-001 Parameter GEN_W, default 16, width of the generation counter.
REQ-002 clk  input  1  pixel-domain clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 init_done  input  1  one-cycle pulse from the clear/init engine: the whole board has been written.
REQ-005 preset_req  input  1  level from the SD preset loader: it wants the write ports.
REQ-006 preset_done  input  1  one-cycle pulse: the preset file has been fully written.
REQ-007 evo_tick  input  1  one-cycle pulse from the evolution timer: compute the next generation.
REQ-008 round_done  input  1  one-cycle pulse from the evolution engine: the last word has been written.
REQ-009 frame_end  input  1  one-cycle pulse at the VGA vertical-sync start.
REQ-010 clear  input  1  one-cycle pulse: wipe the board.
REQ-011 init_start  output  1  one-cycle pulse that starts the init engine.
REQ-012 round_start  output  1  one-cycle pulse that starts the evolution engine.
REQ-013 owner  output  2  write-port owner: 0 none, 1 init, 2 preset, 3 round.
REQ-014 active_bank  output  1  bank pair read by VGA; round reads the active pair and writes the other.
REQ-015 vga_blank  output  1  forces black video while the board is being rewritten.
REQ-016 gen_count  output  GEN_W  number of generations committed.
REQ-017 tick_overrun  output  1  sticky flag: an evo_tick was dropped.

Function
REQ-018 The block SHALL have five states: INIT, PRESET, IDLE, EVOLVE and SWAP_WAIT.
REQ-019 owner SHALL be 1 in INIT, 2 in PRESET, 3 in EVOLVE, and 0 in IDLE and SWAP_WAIT.
REQ-020 vga_blank SHALL be 1 exactly in INIT and PRESET, and 0 otherwise.
REQ-021 INIT: init_start SHALL pulse in the first cycle of the state; on init_done the block SHALL go to IDLE in the next cycle.
REQ-022 IDLE priority, highest first:
- clear: go to INIT; gen_count <= 0; active_bank <= 0; pending tick cleared.
- preset_req: go to PRESET.
- evo_tick, or a pending tick: go to EVOLVE; round_start pulses in the cycle the state is entered; pending tick cleared.
REQ-023 PRESET: on preset_done the block SHALL go to IDLE; active_bank and gen_count SHALL be unchanged.
REQ-024 EVOLVE: on round_done the block SHALL go to SWAP_WAIT.
REQ-025 A frame_end in the same cycle as round_done SHALL NOT commit; the swap waits for the next frame_end.
REQ-026 SWAP_WAIT: on frame_end, active_bank SHALL toggle and gen_count SHALL increment by 1, wrapping modulo 2^GEN_W, in the same edge; the block then goes to IDLE.
REQ-027 An evo_tick outside IDLE SHALL set a one-deep pending flag.
REQ-028 An evo_tick while the pending flag is already set SHALL set tick_overrun; tick_overrun clears only on rst.
REQ-029 An evo_tick in IDLE while a tick is pending SHALL be absorbed by that pending tick (not an overrun).
REQ-030 clear in PRESET or SWAP_WAIT SHALL go to INIT immediately, with the same clears as in IDLE; an uncommitted swap is discarded.
REQ-031 clear in EVOLVE SHALL set clear_pending; on round_done the block SHALL go to INIT instead of SWAP_WAIT, with no swap.
REQ-032 clear in INIT SHALL restart INIT, pulsing init_start again.
REQ-033 round_done outside EVOLVE, and init_done/preset_done in any non-matching state, SHALL be ignored.
REQ-034 At most one of init_start and round_start SHALL be high in any cycle.

Reset
REQ-035 While rst is high: state = INIT; init_start = 0; round_start = 0; owner = 1; vga_blank = 1; active_bank = 0; gen_count = 0; tick_overrun = 0; pending tick and clear_pending cleared.
REQ-036 init_start SHALL pulse in the first clk edge after rst deasserts.
REQ-037 rst asserted mid-operation (EVOLVE or SWAP_WAIT) SHALL discard any uncommitted generation.

Verification
REQ-038 Release rst, pulse init_done 20 cycles later -> init_start pulses once at cycle 1; owner=1 and vga_blank=1 until init_done; then IDLE with owner=0, vga_blank=0.
REQ-039 From IDLE: evo_tick, round_done 100 cycles later, frame_end 50 cycles after that -> round_start pulses once; owner=3 during the round; active_bank 0->1 and gen_count 0->1 only on that frame_end.
REQ-040 round_done and frame_end in the same cycle, second frame_end 200 cycles later -> no swap on the first; swap and gen_count=1 on the second.
REQ-041 Three evo_tick pulses during one EVOLVE -> tick_overrun=1; after the commit, EVOLVE re-enters once immediately and gen_count reaches 2 after the second round.
REQ-042 clear during EVOLVE, then round_done -> no swap; state INIT; gen_count=0; active_bank=0; init_start pulses.
REQ-043 preset_req in the same cycle as evo_tick in IDLE -> PRESET first with owner=2; after preset_done, EVOLVE runs from the pending tick.
